// File: rtl/weightbuffer_pingpong_ctrl_pkg.sv
// rtl/weightbuffer_pingpong_ctrl_pkg.sv - shared types and helpers for the weight buffer ping-pong controller
package weightbuffer_pingpong_ctrl_pkg;

    typedef enum logic [2:0] {
        SET_EMPTY   = 3'd0,
        SET_FILLING = 3'd1,
        SET_FULL    = 3'd2,
        SET_ACTIVE  = 3'd3,
        SET_FLUSH   = 3'd4
    } set_state_e;

    typedef struct packed {
        int s;
        int k1;
        int k2;
    } beat_pos_t;

    localparam int DEF_K              = 3;
    localparam int DEF_WEIGHT_STAGGER = 2;

    function automatic int calc_bps(input int k, input int ws);
        return k * k * ws;
    endfunction

    function automatic int beat_cnt_width(input int bps);
        return (bps > 1) ? $clog2(bps) : 1;
    endfunction

    localparam int BEAT_CNT_W = beat_cnt_width(calc_bps(DEF_K, DEF_WEIGHT_STAGGER));

    // Stagger index is innermost, then k2, then k1.
    function automatic beat_pos_t decode_beat(input int beat, input int k, input int ws);
        beat_pos_t p;
        p.s  = beat % ws;
        p.k2 = (beat / ws) % k;
        p.k1 = (beat / ws) / k;
        return p;
    endfunction

endpackage

// File: rtl/weightbuffer_pingpong_ctrl_set_fsm.sv
// rtl/weightbuffer_pingpong_ctrl_set_fsm.sv - lifecycle state machine of one weight set
module weightbuffer_set_fsm
    import weightbuffer_pingpong_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       done_i,
    input  logic       promote_i,
    input  logic       release_i,
    input  logic       abort_i,
    output set_state_e state_o,
    output logic       flush_o
);

    set_state_e state_q;
    set_state_e state_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SET_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = SET_FLUSH;
        end else begin
            case (state_q)
                SET_EMPTY:   if (start_i)   state_d = done_i ? SET_FULL : SET_FILLING;
                SET_FILLING: if (done_i)    state_d = SET_FULL;
                SET_FULL:    if (promote_i) state_d = SET_ACTIVE;
                SET_ACTIVE:  if (release_i) state_d = SET_FLUSH;
                SET_FLUSH:                  state_d = SET_EMPTY;
                default:                    state_d = SET_EMPTY;
            endcase
        end
    end

    assign state_o = state_q;
    assign flush_o = (state_q == SET_FLUSH);

endmodule

// File: rtl/weightbuffer_pingpong_ctrl.sv
// rtl/weightbuffer_pingpong_ctrl.sv - double-buffered K x K weight buffer load sequencer
module weightbuffer_pingpong_ctrl
    import weightbuffer_pingpong_ctrl_pkg::*;
#(
    parameter int N_I            = 512,
    parameter int WEIGHT_STAGGER = 2,
    parameter int K              = 3
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  logic [N_I/WEIGHT_STAGGER-1:0][1:0]                   data_i,
    input  logic                                                 valid_i,
    output logic                                                 ready_o,
    input  logic                                                 abort_i,
    input  logic                                                 release_i,
    input  logic                                                 test_mode_i,
    output logic [N_I/WEIGHT_STAGGER-1:0][1:0]                   data_o,
    output logic [1:0][WEIGHT_STAGGER-1:0][K-1:0][K-1:0]         save_enable_o,
    output logic [1:0][WEIGHT_STAGGER-1:0][K-1:0][K-1:0]         test_enable_o,
    output logic [1:0][WEIGHT_STAGGER-1:0]                       flush_o,
    output logic                                                 act_valid_o,
    output logic                                                 act_set_o,
    output logic                                                 err_o
);

    localparam int BPS    = calc_bps(K, WEIGHT_STAGGER);
    localparam int CNT_W  = beat_cnt_width(BPS);
    localparam int SAVE_W = 2 * WEIGHT_STAGGER * K * K;

    set_state_e               state [2];
    logic [1:0]               set_flush;
    logic [1:0]               start;
    logic [1:0]               done;
    logic [1:0]               promote;
    logic [1:0]               rel_set;
    logic                     fill_set_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     fill_open;
    logic                     accept;
    logic                     last_beat;
    logic                     any_active;
    logic                     release_ok;
    beat_pos_t                pos;
    int                       save_idx;
    logic [SAVE_W-1:0]        save_d;

    for (genvar g = 0; g < 2; g++) begin : g_set
        weightbuffer_set_fsm u_set_fsm (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .start_i   (start[g]),
            .done_i    (done[g]),
            .promote_i (promote[g]),
            .release_i (rel_set[g]),
            .abort_i   (abort_i),
            .state_o   (state[g]),
            .flush_o   (set_flush[g])
        );
    end

    // A set in FLUSH is neither EMPTY nor FILLING, so writes and flushes never overlap.
    assign fill_open  = (state[fill_set_q] == SET_EMPTY) || (state[fill_set_q] == SET_FILLING);
    assign ready_o    = fill_open & ~abort_i & ~rst_i;
    assign accept     = valid_i & ready_o;
    assign last_beat  = (cnt_q == CNT_W'(BPS - 1));
    assign any_active = (state[0] == SET_ACTIVE) || (state[1] == SET_ACTIVE);
    assign release_ok = release_i & ~abort_i & any_active;

    always_comb begin
        start            = '0;
        done             = '0;
        start[fill_set_q] = accept & (state[fill_set_q] == SET_EMPTY);
        done[fill_set_q]  = accept & last_beat;
        rel_set[0]       = release_ok & (state[0] == SET_ACTIVE);
        rel_set[1]       = release_ok & (state[1] == SET_ACTIVE);
        // A set leaving ACTIVE frees the slot on the same edge; set 0 wins a tie.
        promote[0]       = (state[0] == SET_FULL) & ((state[1] != SET_ACTIVE) | rel_set[1]);
        promote[1]       = (state[1] == SET_FULL) & ((state[0] != SET_ACTIVE) | rel_set[0])
                           & ~promote[0];
    end

    always_comb begin
        pos      = decode_beat(int'(cnt_q), K, WEIGHT_STAGGER);
        save_idx = ((int'(fill_set_q) * WEIGHT_STAGGER + pos.s) * K + pos.k1) * K + pos.k2;
        save_d   = SAVE_W'(1) << save_idx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_set_q    <= 1'b0;
            cnt_q         <= '0;
            data_o        <= '0;
            save_enable_o <= '0;
            err_o         <= 1'b0;
        end else begin
            save_enable_o <= accept ? save_d : '0;
            if (accept) begin
                data_o <= data_i;
            end
            if (release_i && !abort_i && !any_active) begin
                err_o <= 1'b1;
            end
            if (abort_i) begin
                cnt_q      <= '0;
                fill_set_q <= 1'b0;
            end else if (accept) begin
                if (last_beat) begin
                    cnt_q      <= '0;
                    fill_set_q <= ~fill_set_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign flush_o[0]    = {WEIGHT_STAGGER{set_flush[0]}};
    assign flush_o[1]    = {WEIGHT_STAGGER{set_flush[1]}};
    assign test_enable_o = test_mode_i ? '1 : save_enable_o;
    assign act_valid_o   = any_active;
    assign act_set_o     = (state[1] == SET_ACTIVE);

endmodule
